// File: rtl/qr_result_serializer_pkg.sv
// Purpose: shared widths, word counts and field-index helper for the QR result serializer.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package qr_pkg;

    localparam int WORD_W  = 20;
    localparam int N_Y     = 8;
    localparam int N_R     = 16;
    localparam int N_WORDS = N_Y + N_R;
    localparam int Y_W     = N_Y * WORD_W;
    localparam int R_W     = N_R * WORD_W;
    localparam int ENTRY_W = 1 + R_W + Y_W;
    localparam int IDX_W   = 5;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    // Entry layout is {last, r, y_hat}, so word idx of the stream sits at
    // bit offset idx*WORD_W for both the y_hat and the R section.
    function automatic logic [8:0] word_lsb(input logic [IDX_W-1:0] idx);
        return {4'b0000, idx} * 9'(WORD_W);
    endfunction

endpackage

// File: rtl/qr_result_serializer_if.sv
// Purpose: word stream from the serializer to the host/DMA side.
// Latency: none (wiring only).
// Backpressure: consumer drives ready; a word moves when valid & ready.
interface qr_result_serializer_if;

    logic                      valid;
    logic                      ready;
    logic [qr_pkg::WORD_W-1:0] data;
    logic                      sof;
    logic                      eof;
    logic                      last;

    modport master (output valid, output data, output sof, output eof, output last, input ready);
    modport slave  (input valid, input data, input sof, input eof, input last, output ready);

endinterface

// File: rtl/qr_result_serializer_fifo.sv
// Purpose: synchronous result FIFO, count-based full/empty, drop-on-full with sticky flag.
// Latency: a push is visible at dout on the cycle after the write edge when the FIFO was empty.
// Backpressure: none upstream; a push with no space is dropped and overflow latches.
module qr_result_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;
    logic          space;

    // A pop in the same cycle frees the head first, so a full FIFO can still accept.
    assign do_pop  = pop && (count != '0);
    assign space   = (count != CW'(DEPTH)) || do_pop;
    assign do_push = push && space;
    assign dout    = mem[rd_ptr];

    // Pointers, occupancy and the sticky drop flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
            if (push && !space) overflow <= 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/qr_result_serializer.sv
// Purpose: capture QR engine results and stream each as 24 x 20-bit words with frame markers.
// Latency: result pushed at edge T into an empty buffer shows word 0 during cycle T+1.
// Backpressure: valid/ready on the output; outputs hold while stalled; results dropped when full.
module qr_result_serializer
    import qr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_rd_vld,
    input  logic                         i_last_data,
    input  logic [Y_W-1:0]               i_y_hat,
    input  logic [R_W-1:0]               i_r,
    qr_result_serializer_if.master       out_if,
    output logic [$clog2(DEPTH):0]       o_level,
    output logic                         o_overflow
);

    logic [ENTRY_W-1:0]     head;
    logic [$clog2(DEPTH):0] count;
    logic [IDX_W-1:0]       idx;
    logic                   valid;
    logic                   xfer;
    logic                   pop;

    assign valid   = (count != '0);
    assign xfer    = valid && out_if.ready;
    assign pop     = xfer && (idx == LAST_IDX);
    assign o_level = count;

    qr_result_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push     (i_rd_vld),
        .din      ({i_last_data, i_r, i_y_hat}),
        .pop      (pop),
        .dout     (head),
        .count    (count),
        .overflow (o_overflow)
    );

    // Word index over the head entry; wraps to 0 when the last word is taken.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx <= '0;
        end else if (xfer) begin
            idx <= pop ? '0 : idx + IDX_W'(1);
        end
    end

    // Output mux from registered state only; forced to zero when nothing is held.
    always_comb begin
        out_if.valid = valid;
        out_if.data  = '0;
        out_if.sof   = 1'b0;
        out_if.eof   = 1'b0;
        out_if.last  = 1'b0;
        if (valid) begin
            out_if.data = head[word_lsb(idx) +: WORD_W];
            out_if.sof  = (idx == '0);
            out_if.eof  = (idx == LAST_IDX);
            out_if.last = (idx == LAST_IDX) && head[ENTRY_W-1];
        end
    end

endmodule

// File: doc/qr_result_serializer.md
Name: qr_result_serializer

Overview:
- Sits directly downstream of the QR engine. Captures each result the engine presents: y_hat (160 b) and upper-triangular R (320 b), together with the last-data flag.
- Buffers captured results in a small FIFO.
- Emits each result as a stream of 20-bit words under a valid/ready handshake, with frame markers for the host/DMA side.
- Decouples the engine's 12-cycle result cadence from a possibly stalling consumer.

Parameters:
- WORD_W, 20, width of one fixed-point real word; y_hat and R are packed as 20-bit fields.
- N_Y, 8, y_hat words per result (4 complex values as re/im pairs).
- N_R, 16, R words per result (4 real diagonal + 6 complex off-diagonal).
- DEPTH, 4, FIFO depth in results; power of two, >= 2.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_rd_vld  in  1  engine result strobe; qualifies i_y_hat, i_r, i_last_data for one cycle
- i_last_data  in  1  this result is the last of the batch
- i_y_hat  in  160  word k = bits [20k+19:20k], k = 0..7
- i_r  in  320  word k = bits [20k+19:20k], k = 0..15
- o_valid  out  1  o_data holds a valid word
- i_ready  in  1  consumer accepts the word when o_valid & i_ready
- o_data  out  20  current output word
- o_sof  out  1  current word is word 0 of a result
- o_eof  out  1  current word is word 23 of a result
- o_last  out  1  o_eof of a result captured with i_last_data = 1
- o_level  out  $clog2(DEPTH)+1  results held, including the one being streamed
- o_overflow  out  1  sticky: a result was dropped

Behaviour:
Reset and interface:
- Reset i_rst, asynchronous, active-high; clock i_clk.
- Reset values: all outputs 0; FIFO empty; word index 0; overflow flag clear.
- Reset mid-operation discards every buffered and partially streamed result. No words are emitted after reset until a new i_rd_vld.

FIFO:
- Each entry is 481 b: {last, r[319:0], y_hat[159:0]}.
- Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. A separate count register runs 0..DEPTH.
- Push on a rising edge with i_rd_vld = 1 and space available.
- Space is available when count < DEPTH, or count == DEPTH and a pop occurs in the same cycle (pop frees the head first).
- i_rd_vld with no space: the result is dropped, o_overflow is set and stays set until reset, and the FIFO is unchanged.

Streaming:
- A 5-bit word index idx runs 0..N_Y+N_R-1 (0..23) over the head entry.
- idx 0..7 select y_hat word idx; idx 8..23 select R word idx-8. Words go out LSB field first.
- o_valid = (count != 0).
- o_data, o_sof, o_eof and o_last are combinational muxes of registered state only; there is no combinational path from any input.
- Transfer = o_valid & i_ready. On a transfer, idx increments. On a transfer at idx 23, idx returns to 0 and the head is popped.
- While o_valid & !i_ready, o_data and all flags hold stable.
- o_sof = o_valid & (idx == 0).
- o_eof = o_valid & (idx == 23).
- o_last = o_eof & head.last.

Timing and boundaries:
- Latency: a result pushed at edge T into an empty FIFO gives word 0 on o_data during cycle T+1.
- Throughput: one word per cycle; a result takes 24 cycles with i_ready held high.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Push into an empty FIFO while idx == 0: the new entry becomes the head immediately.
- o_level = count.

Decomposition:
- Shared package qr_pkg holds WORD_W, N_Y, N_R, the words-per-result constant (24) and the field-index helper.
- One natural sub-module: qr_result_fifo, a parameterised synchronous FIFO with count-based full/empty, simultaneous push/pop and a drop-on-full flag.
- The serializer wraps it with the word index and the output mux.

Test Plan:
1. Reset, then one i_rd_vld with i_y_hat word k = k+1 and i_r word k = 16'h100+k, i_ready held 1.
   -> From the next cycle: 24 consecutive words 1..8 then 0x100..0x10F. o_sof on the first word, o_eof on the 24th, o_last = 0, o_valid drops afterwards.
2. Same result but i_ready toggling 1,0,1,0...
   -> 24 words delivered over 47 cycles, in order. o_data is stable through every stall cycle; no word duplicated or skipped.
3. i_ready = 0 and 5 results pushed 12 cycles apart with DEPTH = 4.
   -> o_level reaches 4 and o_overflow rises on the 5th push. After releasing i_ready, exactly the first 4 results stream out.
4. FIFO full (i_ready = 1, 4 results queued), a new i_rd_vld in the same cycle as word 23 of the head.
   -> The new result is accepted, o_overflow stays 0, and o_level stays 4.
5. A batch of 10 results with i_last_data = 1 on the 10th.
   -> o_last is asserted exactly once, coincident with o_eof of the 10th result.
6. i_rst pulsed while streaming idx = 13 with 2 results queued.
   -> o_valid = 0 and o_level = 0 immediately. The next push streams from word 0 with o_sof = 1.
